// File: rtl/uplink_rr_arbiter_if.sv
// Requester-side and router-side handshake bundle for the uplink arbiter.
// The arbiter uses the master view; the NIs/router environment uses the slave view.
interface uplink_rr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16
);
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        input  req_data,
        input  req_valid,
        input  out_ready,
        output req_ready,
        output out_data,
        output out_valid
    );

    modport slave (
        output req_data,
        output req_valid,
        output out_ready,
        input  req_ready,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/uplink_rr_arbiter.sv
// Round-robin arbiter with bounded burst locking that feeds one router injection port
// from N_REQ NIs through a single registered output stage; null-header words are dropped.
module uplink_rr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = 16,
    parameter int HEADER_W   = 6,
    parameter int BURST_MAX  = 4,
    parameter int DROP_CNT_W = 8,
    parameter int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    uplink_rr_arbiter_if.master   bus,
    output logic [IDX_W-1:0]      grant_id,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    localparam int                CNT_W       = 4;
    localparam logic [0:0]        ST_IDLE     = 1'b0;
    localparam logic [0:0]        ST_BURST    = 1'b1;
    localparam logic [CNT_W-1:0]  BURST_MAX_C = CNT_W'(BURST_MAX);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(N_REQ - 1);

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [IDX_W-1:0]      grant_id_q, grant_id_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic                  load_en;
    logic                  burst_hold;
    logic                  rr_found;
    logic                  win_found;
    logic                  win_null;
    logic                  accept;
    logic [IDX_W-1:0]      cand;
    logic [IDX_W-1:0]      rr_idx;
    logic [IDX_W-1:0]      win_idx;
    logic [DATA_W-1:0]     win_word;
    logic [CNT_W-1:0]      next_cnt;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Cyclic search for the first valid requester starting at rr_ptr.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = rr_ptr_q;
        cand     = rr_ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!rr_found && bus.req_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
            cand = idx_inc(cand);
        end
    end

    always_comb begin
        load_en    = !out_valid_q || bus.out_ready;
        burst_hold = (state_q == ST_BURST) && bus.req_valid[owner_q] &&
                     (burst_cnt_q < BURST_MAX_C);
        win_found  = burst_hold || rr_found;
        win_idx    = burst_hold ? owner_q : rr_idx;
        win_word   = bus.req_data[win_idx*DATA_W +: DATA_W];
        win_null   = (win_word[DATA_W-1 -: HEADER_W] == '0);
        accept     = reset_n && win_found && load_en;
        bus.req_ready = '0;
        if (reset_n && win_found) begin
            bus.req_ready[win_idx] = load_en;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        grant_id_d  = grant_id_q;
        drop_cnt_d  = drop_cnt_q;
        next_cnt    = burst_hold ? burst_cnt_q + 1'b1 : CNT_W'(1);

        if (load_en) begin
            out_valid_d = 1'b0;
        end

        // Owner went quiet while the stage could move: close the burst, owner to the back.
        if ((state_q == ST_BURST) && load_en && !bus.req_valid[owner_q]) begin
            state_d     = ST_IDLE;
            rr_ptr_d    = idx_inc(owner_q);
            burst_cnt_d = '0;
        end

        if (accept) begin
            grant_id_d = win_idx;
            owner_d    = win_idx;
            if (win_null) begin
                drop_cnt_d = sat_inc(drop_cnt_q);
            end else begin
                out_data_d  = win_word;
                out_valid_d = 1'b1;
            end
            if (next_cnt == BURST_MAX_C) begin
                state_d     = ST_IDLE;
                rr_ptr_d    = idx_inc(win_idx);
                burst_cnt_d = '0;
            end else begin
                state_d     = ST_BURST;
                burst_cnt_d = next_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            grant_id_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            grant_id_q  <= grant_id_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign grant_id      = grant_id_q;
    assign drop_cnt      = drop_cnt_q;
endmodule

// File: doc/uplink_rr_arbiter.md
Name: uplink_rr_arbiter

Overview:
- Shares one router injection port between N_REQ network-interface requesters in a leaf group (four GPU NIs) using round-robin arbitration with bounded burst locking.
- Sits between the per-GPU NIs and the group router's local input port.
- Registers the selected word into a single output stage with a valid/ready handshake.
- Discards words whose routing header is the null address 000000, which is the NI lookup miss code, and counts them.

Parameters:
- N_REQ, 4, number of requesters; requester index width IDX_W = clog2(N_REQ), 2 by default.
- DATA_W, 16, flit width.
- HEADER_W, 6, routing header width, taken as flit bits [DATA_W-1:DATA_W-HEADER_W].
- BURST_MAX, 4, maximum consecutive accepted words per grant. Legal range 1..15.
- DROP_CNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_data  in  N_REQ*DATA_W  requester flits; requester i occupies bits [i*DATA_W +: DATA_W].
- req_valid  in  N_REQ  per-requester valid.
- req_ready  out  N_REQ  per-requester ready; combinational, at most one bit high.
- out_data  out  DATA_W  registered flit to the router.
- out_valid  out  1  registered valid.
- out_ready  in  1  router ready.
- grant_id  out  IDX_W  index of the requester whose word was most recently accepted.
- drop_cnt  out  DROP_CNT_W  saturating count of discarded null-header words.

Behaviour:
- Reset (asynchronous, immediate on reset_n low):
  - out_valid=0, out_data=0, grant_id=0, drop_cnt=0.
  - state=IDLE, rr_ptr=0, owner=0, burst_cnt=0.
  - Any word held in the output stage is lost. req_ready=0 while reset_n is low.
- Load enable: load_en = !out_valid || out_ready. The output stage can refill in the same cycle it drains, giving full throughput.
- Winner selection (combinational):
  - If state=BURST, req_valid[owner]=1 and burst_cnt<BURST_MAX, the winner is owner.
  - Otherwise the winner is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - If no requester is valid, there is no winner.
- Handshake:
  - req_ready[winner]=load_en; every other req_ready bit is 0.
  - An accept is req_valid[i] && req_ready[i].
  - req_ready never depends on out_valid of the previous word beyond load_en.
- On accept of word w from requester i:
  - If the header of w is nonzero: out_data<=w, out_valid<=1. Latency is one cycle from accept to out_valid.
  - If the header of w is 0: the word is consumed. out_valid<=0 unless the current word is held because out_ready=0. drop_cnt increments, saturating at all-ones.
  - grant_id<=i.
  - A dropped word still counts toward the burst.
- Output hold: while out_valid=1 and out_ready=0, out_data and out_valid stay stable, and no requester is ready.
- Drain without refill: out_valid=1, out_ready=1 and no accept gives out_valid<=0 next cycle.
- FSM:
  - IDLE -> BURST on any accept: owner<=i, burst_cnt<=1.
  - In BURST, an accept from owner sets burst_cnt<=burst_cnt+1.
  - The burst ends when the accept makes burst_cnt==BURST_MAX, or when a cycle has load_en=1 and req_valid[owner]=0. On burst end: state<=IDLE, rr_ptr<=owner+1 mod N_REQ, burst_cnt<=0.
  - With BURST_MAX=1, each accept ends the burst immediately, giving pure round-robin.
  - A stall (load_en=0) never ends a burst.
  - When a burst ends because the cap is hit, the owner is lowest priority in the next arbitration. It is re-granted only if no other requester is valid.
- Fairness: with all N_REQ requesters continuously valid and out_ready=1, each requester receives exactly BURST_MAX consecutive accepts in cyclic order.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, then all req_valid=0 -> out_valid=0, req_ready=0000, drop_cnt=0, grant_id=0 throughout.
- Single requester: req 2 is continuously valid with flits 0x4401, 0x4402, ..., out_ready=1 -> first out_valid 1 cycle after the first accept. Output order is 0x4401, 0x4402, ... with no gaps. grant_id=2.
- Round-robin with burst cap: all 4 requesters valid, BURST_MAX=4, out_ready=1 -> accept sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0... One word per cycle.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> out_data stays stable, req_ready=0000, burst_cnt unchanged. After out_ready=1, the next word follows on the next cycle.
- Null header: req 1 sends 0x0123, then 0x4411 -> 0x0123 is never presented on out_data, drop_cnt=1, 0x4411 is output. Forcing 300 drops -> drop_cnt=255.
- Mid-burst reset: assert reset_n=0 asynchronously while req 3 holds burst_cnt=2 and out_valid=1 -> out_valid drops without waiting for a clock edge. After release, arbitration starts from rr_ptr=0.
